// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and constants for the data-cache write path
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B
    } drain_state_e;

    localparam logic [2:0] AXI_SIZE_4B = 3'b010;

    typedef struct packed {
        logic [31:0] addr;
        logic        uncache;
        logic [3:0]  strb;
    } vb_entry_t;

endpackage

// File: rtl/dcache_victim_buf_if.sv
// rtl/dcache_victim_buf_if.sv - producer, lookup, AXI write and status signals of the victim buffer
interface dcache_victim_buf_if #(
    parameter int DEPTH      = 4,
    parameter int LINE_WORDS = 16
);
    logic                       push_valid;
    logic                       push_ready;
    logic [31:0]                push_addr;
    logic [LINE_WORDS*32-1:0]   push_line;
    logic                       push_uncache;
    logic [3:0]                 push_strb;
    logic [31:0]                lookup_addr;
    logic                       lookup_hit;
    logic [LINE_WORDS*32-1:0]   lookup_line;
    logic                       awvalid;
    logic                       awready;
    logic [31:0]                awaddr;
    logic [7:0]                 awlen;
    logic [2:0]                 awsize;
    logic                       wvalid;
    logic                       wready;
    logic [31:0]                wdata;
    logic [3:0]                 wstrb;
    logic                       wlast;
    logic                       bvalid;
    logic                       bready;
    logic                       empty;
    logic [$clog2(DEPTH):0]     count;

    modport slave (
        input  push_valid, push_addr, push_line, push_uncache, push_strb, lookup_addr,
        input  awready, wready, bvalid,
        output push_ready, lookup_hit, lookup_line,
        output awvalid, awaddr, awlen, awsize, wvalid, wdata, wstrb, wlast, bready,
        output empty, count
    );

    modport master (
        output push_valid, push_addr, push_line, push_uncache, push_strb, lookup_addr,
        output awready, wready, bvalid,
        input  push_ready, lookup_hit, lookup_line,
        input  awvalid, awaddr, awlen, awsize, wvalid, wdata, wstrb, wlast, bready,
        input  empty, count
    );
endinterface

// File: rtl/victim_lookup.sv
// rtl/victim_lookup.sv - parallel line-address compare with newest-entry-wins select
module victim_lookup #(
    parameter int DEPTH      = 4,
    parameter int LINE_WORDS = 16
) (
    input  logic [31:0]                          lookup_addr_i,
    input  logic [31-$clog2(LINE_WORDS*4):0]     tag_i [DEPTH],
    input  logic [DEPTH-1:0]                     cand_i,
    input  logic [LINE_WORDS*32-1:0]             line_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]             wr_ptr_i,
    output logic                                 hit_o,
    output logic [LINE_WORDS*32-1:0]             line_o
);
    localparam int PW   = $clog2(DEPTH);
    localparam int OFFW = $clog2(LINE_WORDS*4);

    logic [PW-1:0] idx;
    logic          unused_lo;

    assign unused_lo = ^lookup_addr_i[OFFW-1:0];

    // Scan oldest to newest so the most recent match overwrites earlier ones.
    always_comb begin
        hit_o  = 1'b0;
        line_o = '0;
        idx    = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = wr_ptr_i - PW'(k);
            if (cand_i[idx] && (tag_i[idx] == lookup_addr_i[31:OFFW])) begin
                hit_o  = 1'b1;
                line_o = line_i[idx];
            end
        end
    end
endmodule

// File: rtl/dcache_victim_buf.sv
// rtl/dcache_victim_buf.sv - circular victim/write buffer draining entries as AXI write bursts
module dcache_victim_buf
    import dcache_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int LINE_WORDS = 16
) (
    input  logic               clk,
    input  logic               rst,
    dcache_victim_buf_if.slave bus
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int BW   = $clog2(LINE_WORDS);
    localparam int OFFW = $clog2(LINE_WORDS*4);

    vb_entry_t                ent_q  [DEPTH];
    logic [LINE_WORDS*32-1:0] line_q [DEPTH];
    logic [DEPTH-1:0]         vld_q;
    logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]            count_q, count_d;
    drain_state_e             state_q, state_d;
    logic [BW-1:0]            beat_q, beat_d;

    logic      push_fire, pop;
    vb_entry_t new_ent, head;
    logic [31-OFFW:0] tag [DEPTH];
    logic [DEPTH-1:0] cand;

    assign bus.push_ready = (count_q != CW'(DEPTH));
    assign push_fire      = bus.push_valid && bus.push_ready;
    assign pop            = (state_q == ST_B) && bus.bvalid;
    assign count_d        = count_q + CW'(push_fire) - CW'(pop);
    assign bus.empty      = (count_q == '0);
    assign bus.count      = count_q;

    always_comb begin
        new_ent.addr    = bus.push_uncache ? bus.push_addr : {bus.push_addr[31:OFFW], {OFFW{1'b0}}};
        new_ent.uncache = bus.push_uncache;
        new_ent.strb    = bus.push_strb;
    end

    // Line data is never reset; only the valid bits decide what exists.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            ent_q[wr_ptr_q]  <= new_ent;
            line_q[wr_ptr_q] <= bus.push_line;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr_q        <= wr_ptr_q + PW'(1);
                vld_q[wr_ptr_q] <= 1'b1;
            end
            if (pop) begin
                rd_ptr_q        <= rd_ptr_q + PW'(1);
                vld_q[rd_ptr_q] <= 1'b0;
            end
            count_q <= count_d;
        end
    end

    assign head       = ent_q[rd_ptr_q];
    assign bus.awaddr = head.addr;
    assign bus.awlen  = head.uncache ? 8'd0 : 8'(LINE_WORDS - 1);
    assign bus.awsize = AXI_SIZE_4B;
    assign bus.wstrb  = head.uncache ? head.strb : 4'hF;
    assign bus.wdata  = line_q[rd_ptr_q][{beat_q, 5'b0} +: 32];
    assign bus.wlast  = (state_q == ST_W) && ({{(8-BW){1'b0}}, beat_q} == bus.awlen);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        case (state_q)
            ST_IDLE: if (count_q != '0) state_d = ST_AW;
            ST_AW: begin
                bus.awvalid = 1'b1;
                if (bus.awready) begin
                    state_d = ST_W;
                    beat_d  = '0;
                end
            end
            ST_W: begin
                bus.wvalid = 1'b1;
                if (bus.wready) begin
                    if (bus.wlast) state_d = ST_B;
                    else           beat_d  = beat_q + BW'(1);
                end
            end
            ST_B: begin
                bus.bready = 1'b1;
                if (bus.bvalid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            tag[i]  = ent_q[i].addr[31:OFFW];
            cand[i] = vld_q[i] && !ent_q[i].uncache;
        end
    end

    victim_lookup #(.DEPTH(DEPTH), .LINE_WORDS(LINE_WORDS)) u_lookup (
        .lookup_addr_i (bus.lookup_addr),
        .tag_i         (tag),
        .cand_i        (cand),
        .line_i        (line_q),
        .wr_ptr_i      (wr_ptr_q),
        .hit_o         (bus.lookup_hit),
        .line_o        (bus.lookup_line)
    );
endmodule

// File: tb/tb_dcache_victim_buf.sv
// tb/tb_dcache_victim_buf.sv - directed-vector bench for dcache_victim_buf
module tb_dcache_victim_buf;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    dcache_victim_buf_if #(.DEPTH(4), .LINE_WORDS(16)) bus ();

    dcache_victim_buf #(.DEPTH(4), .LINE_WORDS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] mk_line(input logic [31:0] b);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = b + 32'(i);
        return l;
    endfunction

    // Called at a negedge; returns at a negedge after the entry was taken.
    task automatic push(input logic [31:0] a, input logic [31:0] base, input logic u, input logic [3:0] s);
        bit ok = 0;
        bus.push_valid   = 1'b1;
        bus.push_addr    = a;
        bus.push_line    = mk_line(base);
        bus.push_uncache = u;
        bus.push_strb    = s;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (bus.push_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("push_accept", 64'(ok), 64'd1);
        @(negedge clk);
        bus.push_valid = 1'b0;
    endtask

    // Completes one burst for the head entry and checks every beat.
    task automatic drain(input logic [31:0] exp_addr, input logic [7:0] exp_len, input logic [31:0] base,
                         input logic [3:0] exp_strb, input bit toggle, input int exp_cnt);
        bit ok = 0;
        bit done = 0;
        bit stall = 0;
        int beat = 0;
        logic [31:0] held = '0;
        bus.awready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (bus.awvalid) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("aw_seen", 64'(ok), 64'd1);
        chk("awaddr", 64'(bus.awaddr), 64'(exp_addr));
        chk("awlen", 64'(bus.awlen), 64'(exp_len));
        chk("awsize", 64'(bus.awsize), 64'd2);
        @(negedge clk);
        bus.awready = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            bus.wready = toggle ? (c % 2 == 0) : 1'b1;
            #1;
            if (bus.wvalid) begin
                if (stall) chk("wdata_hold", 64'(bus.wdata), 64'(held));
                if (bus.wready) begin
                    chk("wdata", 64'(bus.wdata), 64'(base + 32'(beat)));
                    chk("wlast", 64'(bus.wlast), 64'(beat == int'(exp_len)));
                    chk("wstrb", 64'(bus.wstrb), 64'(exp_strb));
                    done  = bus.wlast;
                    beat++;
                    stall = 0;
                end else begin
                    stall = 1;
                    held  = bus.wdata;
                end
            end else if (beat > 0) begin
                chk("wvalid_mid", 64'(bus.wvalid), 64'd1);
            end
            @(negedge clk);
        end
        chk("beats", 64'(beat), 64'(int'(exp_len) + 1));
        bus.wready = 1'b0;
        #1 chk("bready", 64'(bus.bready), 64'd1);
        @(negedge clk);
        bus.bvalid = 1'b1;
        @(negedge clk);
        bus.bvalid = 1'b0;
        #1;
        chk("count_after_b", 64'(bus.count), 64'(exp_cnt));
        chk("ready_after_b", 64'(bus.push_ready), 64'd1);
        chk("empty_after_b", 64'(bus.empty), 64'(exp_cnt == 0));
    endtask

    initial begin
        int n;
        bus.push_valid   = 1'b0;
        bus.push_addr    = '0;
        bus.push_line    = '0;
        bus.push_uncache = 1'b0;
        bus.push_strb    = '0;
        bus.lookup_addr  = '0;
        bus.awready      = 1'b0;
        bus.wready       = 1'b0;
        bus.bvalid       = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_awvalid", 64'(bus.awvalid), 64'd0);
        chk("rst_wvalid", 64'(bus.wvalid), 64'd0);
        chk("rst_bready", 64'(bus.bready), 64'd0);
        chk("rst_wlast", 64'(bus.wlast), 64'd0);
        chk("rst_hit", 64'(bus.lookup_hit), 64'd0);
        chk("rst_ready", 64'(bus.push_ready), 64'd1);
        chk("rst_empty", 64'(bus.empty), 64'd1);
        chk("rst_count", 64'(bus.count), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Cached line, aligned address, lookup before drain.
        push(32'h1234_5678, 32'd0, 1'b0, 4'h0);
        bus.lookup_addr = 32'h1234_567C;
        #1;
        chk("t1_hit", 64'(bus.lookup_hit), 64'd1);
        chk("t1_line_w3", 64'(bus.lookup_line[3*32 +: 32]), 64'd3);
        drain(32'h1234_5640, 8'd15, 32'd0, 4'hF, 1'b0, 0);

        // Uncached single word never hits.
        push(32'h8000_0003, 32'hAABB_CCDD, 1'b1, 4'b1000);
        bus.lookup_addr = 32'h8000_0000;
        #1 chk("t2_hit", 64'(bus.lookup_hit), 64'd0);
        drain(32'h8000_0003, 8'd0, 32'hAABB_CCDD, 4'b1000, 1'b0, 0);

        // Fill with AW stalled; fifth push refused.
        for (int i = 0; i < 4; i++) push(32'h100 * (i + 1), 32'h100 * (i + 1), 1'b0, 4'h0);
        #1;
        chk("t3_count", 64'(bus.count), 64'd4);
        chk("t3_ready", 64'(bus.push_ready), 64'd0);
        chk("t3_awaddr_held", 64'(bus.awaddr), 64'h100);
        @(negedge clk);
        bus.push_valid = 1'b1;
        bus.push_addr  = 32'h900;
        bus.push_line  = mk_line(32'h900);
        @(negedge clk);
        bus.push_valid = 1'b0;
        #1 chk("t3_fifth_refused", 64'(bus.count), 64'd4);
        for (int i = 0; i < 4; i++)
            drain(32'h100 * (i + 1), 8'd15, 32'h100 * (i + 1), 4'hF, 1'b0, 3 - i);

        // Duplicate line: lookup returns the newer copy, drains in push order.
        push(32'h0000_A000, 32'h1000, 1'b0, 4'h0);
        push(32'h0000_A010, 32'h2000, 1'b0, 4'h0);
        bus.lookup_addr = 32'h0000_A020;
        #1;
        chk("t4_hit", 64'(bus.lookup_hit), 64'd1);
        chk("t4_line_w0", 64'(bus.lookup_line[31:0]), 64'h2000);
        chk("t4_line_w15", 64'(bus.lookup_line[511:480]), 64'h200F);
        bus.lookup_addr = 32'h0000_B000;
        #1;
        chk("t4_miss", 64'(bus.lookup_hit), 64'd0);
        chk("t4_miss_line", 64'(bus.lookup_line[63:0]), 64'd0);
        drain(32'h0000_A000, 8'd15, 32'h1000, 4'hF, 1'b0, 1);
        drain(32'h0000_A000, 8'd15, 32'h2000, 4'hF, 1'b0, 0);

        // Toggling wready.
        push(32'h0000_4000, 32'h3000, 1'b0, 4'h0);
        drain(32'h0000_4000, 8'd15, 32'h3000, 4'hF, 1'b1, 0);

        // Reset in the middle of a burst.
        push(32'h0000_6000, 32'h5000, 1'b0, 4'h0);
        bus.awready = 1'b1;
        bus.wready  = 1'b1;
        n = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (bus.wvalid && bus.wready) begin
                if (n == 5) break;
                n++;
            end
            @(negedge clk);
        end
        chk("t6_reached_beat5", 64'(n), 64'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        #1;
        chk("t6_wvalid", 64'(bus.wvalid), 64'd0);
        chk("t6_empty", 64'(bus.empty), 64'd1);
        chk("t6_ready", 64'(bus.push_ready), 64'd1);
        @(negedge clk);
        push(32'h0000_8000, 32'h7000, 1'b0, 4'h0);
        drain(32'h0000_8000, 8'd15, 32'h7000, 4'hF, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
